// File: rtl/combo_lock_fsm_if.sv
// Combination-lock handshake bundle.
// Groups the keypad symbol stream, the relock/programming controls and the
// lock status outputs between the keypad encoder and combo_lock_fsm.
//   master : drives sym_valid, sym, relock, prog_we, prog_code; reads status
//   slave  : the lock itself; reads the controls, drives unlock, locked_out,
//            fail_cnt, entry_active
interface combo_lock_fsm_if #(
    parameter int SYM_W    = 2,
    parameter int CODE_LEN = 6,
    parameter int MAX_FAIL = 3
);
    localparam int FC_W = $clog2(MAX_FAIL + 1);

    logic                      sym_valid;
    logic [SYM_W-1:0]          sym;
    logic                      relock;
    logic                      prog_we;
    logic [CODE_LEN*SYM_W-1:0] prog_code;
    logic                      unlock;
    logic                      locked_out;
    logic [FC_W-1:0]           fail_cnt;
    logic                      entry_active;

    modport master (
        output sym_valid, sym, relock, prog_we, prog_code,
        input  unlock, locked_out, fail_cnt, entry_active
    );

    modport slave (
        input  sym_valid, sym, relock, prog_we, prog_code,
        output unlock, locked_out, fail_cnt, entry_active
    );
endinterface

// File: rtl/combo_lock_fsm.sv
// Parametrised combination lock with failed-attempt lockout, mid-attempt
// inactivity timeout, timed auto-relock and code reprogramming while open.
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high; restores CODE_INIT as the code
//   bus    : combo_lock_fsm_if.slave (symbol stream, relock, programming,
//            registered status outputs)
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_LOCKED   | collecting CODE_LEN-symbol attempts, door closed
// ST_UNLOCKED | correct code seen; door open, code may be reprogrammed
// ST_LOCKOUT  | MAX_FAIL consecutive failures; all input ignored for a while
module combo_lock_fsm #(
    parameter int                        SYM_W       = 2,
    parameter int                        CODE_LEN    = 6,
    parameter logic [CODE_LEN*SYM_W-1:0] CODE_INIT   = 12'b10_01_00_00_01_00,
    parameter int                        MAX_FAIL    = 3,
    parameter int                        LOCKOUT_CYC = 16,
    parameter int                        TIMEOUT_CYC = 64,
    parameter int                        UNLOCK_CYC  = 0
) (
    input  logic              clk,
    input  logic              reset,
    combo_lock_fsm_if.slave   bus
);
    localparam int CODE_W = CODE_LEN * SYM_W;
    localparam int IDX_W  = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
    localparam int FC_W   = $clog2(MAX_FAIL + 1);
    localparam int TO_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int LO_W   = $clog2(LOCKOUT_CYC + 1);
    localparam int OP_W   = (UNLOCK_CYC > 0) ? $clog2(UNLOCK_CYC + 1) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CODE_LEN - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [LO_W-1:0]  LO_LAST  = LO_W'(LOCKOUT_CYC - 1);
    localparam logic [OP_W-1:0]  OP_LAST  = OP_W'(UNLOCK_CYC - 1);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               mis_q, mis_d;
    logic [FC_W-1:0]    fail_q, fail_d;
    logic [TO_W-1:0]    to_q, to_d;
    logic [LO_W-1:0]    lo_q, lo_d;
    logic [OP_W-1:0]    op_q, op_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic               unlock_q, unlock_d;
    logic               locked_out_q, locked_out_d;
    logic               entry_active_q, entry_active_d;

    logic [SYM_W-1:0]   code_sym;
    logic               mis_now;

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mis_d    = mis_q;
        fail_d   = fail_q;
        to_d     = to_q;
        lo_d     = lo_q;
        op_d     = op_q;
        code_d   = code_q;
        code_sym = code_q[int'(idx_q) * SYM_W +: SYM_W];
        mis_now  = mis_q | (bus.sym != code_sym);

        case (state_q)
            ST_LOCKED: begin
                if (bus.sym_valid) begin
                    to_d = '0;
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + IDX_W'(1);
                        mis_d = mis_now;
                    end else begin
                        // Whole attempt consumed; mismatch is judged only here
                        // so a wrong symbol never shortens the attempt.
                        idx_d = '0;
                        mis_d = 1'b0;
                        if (!mis_now) begin
                            state_d = ST_UNLOCKED;
                            fail_d  = '0;
                            op_d    = '0;
                        end else if (int'(fail_q) + 1 < MAX_FAIL) begin
                            fail_d = fail_q + FC_W'(1);
                        end else begin
                            state_d = ST_LOCKOUT;
                            fail_d  = FC_W'(MAX_FAIL);
                            lo_d    = '0;
                        end
                    end
                end else if (idx_q != '0 && TIMEOUT_CYC != 0) begin
                    // Abandoned attempt: drop it without counting a failure.
                    if (to_q == TO_LAST) begin
                        idx_d = '0;
                        mis_d = 1'b0;
                        to_d  = '0;
                    end else begin
                        to_d = to_q + TO_W'(1);
                    end
                end
            end

            ST_UNLOCKED: begin
                if (bus.prog_we) begin
                    code_d = bus.prog_code;
                end
                if (bus.relock) begin
                    state_d = ST_LOCKED;
                    idx_d   = '0;
                    op_d    = '0;
                end else if (UNLOCK_CYC != 0) begin
                    if (op_q == OP_LAST) begin
                        state_d = ST_LOCKED;
                        idx_d   = '0;
                        op_d    = '0;
                    end else begin
                        op_d = op_q + OP_W'(1);
                    end
                end
            end

            ST_LOCKOUT: begin
                if (lo_q == LO_LAST) begin
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                    lo_d    = '0;
                end else begin
                    lo_d = lo_q + LO_W'(1);
                end
            end

            default: begin
                state_d = ST_LOCKED;
                idx_d   = '0;
                mis_d   = 1'b0;
            end
        endcase

        // Status flops are loaded from next-state so they track state_q exactly.
        unlock_d       = (state_d == ST_UNLOCKED);
        locked_out_d   = (state_d == ST_LOCKOUT);
        entry_active_d = (idx_d != '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_LOCKED;
            idx_q          <= '0;
            mis_q          <= 1'b0;
            fail_q         <= '0;
            to_q           <= '0;
            lo_q           <= '0;
            op_q           <= '0;
            code_q         <= CODE_INIT;
            unlock_q       <= 1'b0;
            locked_out_q   <= 1'b0;
            entry_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            mis_q          <= mis_d;
            fail_q         <= fail_d;
            to_q           <= to_d;
            lo_q           <= lo_d;
            op_q           <= op_d;
            code_q         <= code_d;
            unlock_q       <= unlock_d;
            locked_out_q   <= locked_out_d;
            entry_active_q <= entry_active_d;
        end
    end

    assign bus.unlock       = unlock_q;
    assign bus.locked_out   = locked_out_q;
    assign bus.fail_cnt     = fail_q;
    assign bus.entry_active = entry_active_q;

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Directed bench for combo_lock_fsm: one instance with default parameters
// and a second with UNLOCK_CYC = 8 for the auto-relock case.
module tb_combo_lock_fsm;
    localparam logic [11:0] DEF_CODE = 12'b10_01_00_00_01_00;
    localparam logic [11:0] WRONG    = 12'b00_00_00_00_00_00;
    localparam logic [11:0] ALL3     = 12'b11_11_11_11_11_11;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;

    combo_lock_fsm_if if_a ();
    combo_lock_fsm_if if_b ();

    combo_lock_fsm dut_a (.clk(clk), .reset(reset), .bus(if_a));
    combo_lock_fsm #(.UNLOCK_CYC(8)) dut_b (.clk(clk), .reset(reset), .bus(if_b));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends symbols 0..n-1 of code on consecutive cycles, symbol 0 first.
    task automatic send_syms(input int which, input logic [11:0] code, input int n);
        logic [11:0] c;
        c = code;
        for (int i = 0; i < n; i++) begin
            if (which == 0) begin
                if_a.sym_valid = 1'b1;
                if_a.sym       = c[i*2 +: 2];
            end else begin
                if_b.sym_valid = 1'b1;
                if_b.sym       = c[i*2 +: 2];
            end
            tick();
        end
        if_a.sym_valid = 1'b0;
        if_b.sym_valid = 1'b0;
    endtask

    task automatic relock_a();
        if_a.relock = 1'b1;
        tick();
        if_a.relock = 1'b0;
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        reset = 1'b1;
        if_a.sym_valid = 1'b0; if_a.sym = '0; if_a.relock = 1'b0;
        if_a.prog_we = 1'b0;   if_a.prog_code = '0;
        if_b.sym_valid = 1'b0; if_b.sym = '0; if_b.relock = 1'b0;
        if_b.prog_we = 1'b0;   if_b.prog_code = '0;
        #2;
        chk("rst_unlock", int'(if_a.unlock), 0);
        chk("rst_locked_out", int'(if_a.locked_out), 0);
        chk("rst_fail", int'(if_a.fail_cnt), 0);
        chk("rst_entry", int'(if_a.entry_active), 0);
        tick(2);
        reset = 1'b0;
        tick();

        // 1: default code unlocks one cycle after the sixth symbol
        send_syms(0, DEF_CODE, 3);
        chk("t1_entry_mid", int'(if_a.entry_active), 1);
        if_a.sym_valid = 1'b1; if_a.sym = 2'd0; tick();
        if_a.sym = 2'd1; tick();
        chk("t1_unlock_before_last", int'(if_a.unlock), 0);
        if_a.sym = 2'd2; tick();
        if_a.sym_valid = 1'b0;
        chk("t1_unlock", int'(if_a.unlock), 1);
        chk("t1_fail", int'(if_a.fail_cnt), 0);
        chk("t1_entry_done", int'(if_a.entry_active), 0);
        relock_a();
        chk("t1_relock", int'(if_a.unlock), 0);

        // 2: three failures -> lockout for 16 cycles, input ignored meanwhile
        send_syms(0, WRONG, 6);
        chk("t2_fail1", int'(if_a.fail_cnt), 1);
        send_syms(0, WRONG, 6);
        chk("t2_fail2", int'(if_a.fail_cnt), 2);
        chk("t2_no_lockout_yet", int'(if_a.locked_out), 0);
        send_syms(0, WRONG, 6);
        chk("t2_lockout", int'(if_a.locked_out), 1);
        chk("t2_fail3", int'(if_a.fail_cnt), 3);
        send_syms(0, DEF_CODE, 6);
        chk("t2_ignored_unlock", int'(if_a.unlock), 0);
        chk("t2_still_lockout", int'(if_a.locked_out), 1);
        tick(9);
        chk("t2_lockout_last", int'(if_a.locked_out), 1);
        tick();
        chk("t2_lockout_end", int'(if_a.locked_out), 0);
        chk("t2_fail_cleared", int'(if_a.fail_cnt), 0);
        send_syms(0, DEF_CODE, 6);
        chk("t2_unlock_after", int'(if_a.unlock), 1);
        relock_a();

        // 3: partial entry abandoned for 64 cycles is dropped, not a failure
        send_syms(0, WRONG, 6);
        chk("t3_fail_pre", int'(if_a.fail_cnt), 1);
        send_syms(0, DEF_CODE, 3);
        chk("t3_entry", int'(if_a.entry_active), 1);
        tick(63);
        chk("t3_entry_63", int'(if_a.entry_active), 1);
        tick();
        chk("t3_entry_timeout", int'(if_a.entry_active), 0);
        chk("t3_fail_kept", int'(if_a.fail_cnt), 1);
        send_syms(0, DEF_CODE, 6);
        chk("t3_unlock", int'(if_a.unlock), 1);
        chk("t3_fail_zero", int'(if_a.fail_cnt), 0);

        // 4: reprogram with relock in the same cycle
        if_a.prog_we = 1'b1; if_a.prog_code = ALL3; if_a.relock = 1'b1;
        tick();
        if_a.prog_we = 1'b0; if_a.relock = 1'b0;
        chk("t4_relocked", int'(if_a.unlock), 0);
        send_syms(0, DEF_CODE, 6);
        chk("t4_old_code_unlock", int'(if_a.unlock), 0);
        chk("t4_old_code_fail", int'(if_a.fail_cnt), 1);
        send_syms(0, ALL3, 6);
        chk("t4_new_code", int'(if_a.unlock), 1);
        relock_a();
        if_a.prog_we = 1'b1; if_a.prog_code = DEF_CODE;
        tick();
        if_a.prog_we = 1'b0;
        send_syms(0, DEF_CODE, 6);
        chk("t4_locked_prog_ignored", int'(if_a.unlock), 0);
        send_syms(0, ALL3, 6);
        chk("t4_code_kept", int'(if_a.unlock), 1);
        relock_a();

        // 5: auto-relock after 8 open cycles
        send_syms(1, DEF_CODE, 6);
        chk("t5_unlock", int'(if_b.unlock), 1);
        tick(7);
        chk("t5_open_8th", int'(if_b.unlock), 1);
        tick();
        chk("t5_auto_relock", int'(if_b.unlock), 0);

        // 6: async reset mid-lockout (A) and mid-attempt (B)
        send_syms(1, DEF_CODE, 2);
        chk("t6_b_entry", int'(if_b.entry_active), 1);
        send_syms(0, WRONG, 6);
        send_syms(0, WRONG, 6);
        send_syms(0, WRONG, 6);
        chk("t6_a_lockout", int'(if_a.locked_out), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t6_a_locked_out", int'(if_a.locked_out), 0);
        chk("t6_a_fail", int'(if_a.fail_cnt), 0);
        chk("t6_a_unlock", int'(if_a.unlock), 0);
        chk("t6_b_entry_rst", int'(if_b.entry_active), 0);
        tick();
        reset = 1'b0;
        tick();
        send_syms(0, DEF_CODE, 6);
        chk("t6_code_reverted", int'(if_a.unlock), 1);
        send_syms(1, DEF_CODE, 6);
        chk("t6_b_unlock", int'(if_b.unlock), 1);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
